seg_display_mux: RTL and testbench

Consumer end of the stopwatch digit interface. Takes the four BCD digits (minutes, seconds-tens, seconds-units, tenths) and drives a 4-digit multiplexed 7-segment display: anode scanning, BCD-to-segment decode, decimal points, optional leading-zero blanking, and per-slot ghosting dead time. Sits between the stopwatch core and the board display pins, on the same clock.

---
 rtl/seg_display_mux.sv | 111 +++++++++++
 tb/tb_seg_display_mux.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_mux.sv
// Four-digit multiplexed 7-segment driver for the stopwatch digits (M.SS.t).
// Scans anodes, decodes BCD, inserts per-slot dead time, and registers all pin outputs.
module seg_display_mux #(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit_min,
  input  logic [3:0] digit_st,
  input  logic [3:0] digit_su,
  input  logic [3:0] digit_tenths,
  input  logic       blank_lead,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] SLOT_LIT  = CNT_W'(BLANK_CYCLES);
  localparam logic [1:0]       IDX_MIN   = 2'd3;

  // Active-high segment pattern {g,f,e,d,c,b,a}; non-BCD codes stay dark.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  logic [CNT_W-1:0] r_slot;
  logic [1:0]       r_idx;
  logic [3:0][3:0]  r_snap;
  logic [3:0]       r_an;
  logic [6:0]       r_seg;
  logic             r_dp;

  logic [CNT_W-1:0] w_slot_nxt;
  logic [1:0]       w_idx_nxt;
  logic             w_snap_ld;
  logic [3:0]       w_digit;
  logic             w_lit;
  logic [3:0]       w_an_act;
  logic [6:0]       w_seg_act;
  logic             w_dp_act;

  // Slot counter wrap, digit advance and end-of-frame snapshot strobe.
  always_comb begin
    w_slot_nxt = r_slot + CNT_W'(1);
    w_idx_nxt  = r_idx;
    w_snap_ld  = 1'b0;
    if (r_slot == SLOT_LAST) begin
      w_slot_nxt = '0;
      w_idx_nxt  = r_idx + 2'd1;
      w_snap_ld  = (r_idx == IDX_MIN);
    end
  end

  // Active-high pin values for the current slot; minutes blanking uses live blank_lead.
  always_comb begin
    w_digit   = r_snap[r_idx];
    w_an_act  = 4'b0000;
    w_seg_act = 7'b0000000;
    w_dp_act  = 1'b0;
    w_lit     = (r_slot >= SLOT_LIT) &&
                !((r_idx == IDX_MIN) && blank_lead && (r_snap[3] == 4'd0));
    if (w_lit) begin
      w_an_act  = 4'b0001 << r_idx;
      w_seg_act = bcd_to_seg(w_digit);
      w_dp_act  = r_idx[0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot <= '0;
      r_idx  <= '0;
      r_snap <= '0;
      r_an   <= {4{ACTIVE_LOW}};
      r_seg  <= {7{ACTIVE_LOW}};
      r_dp   <= ACTIVE_LOW;
    end else begin
      r_slot <= w_slot_nxt;
      r_idx  <= w_idx_nxt;
      if (w_snap_ld) begin
        r_snap <= {digit_min, digit_st, digit_su, digit_tenths};
      end
      r_an   <= w_an_act ^ {4{ACTIVE_LOW}};
      r_seg  <= w_seg_act ^ {7{ACTIVE_LOW}};
      r_dp   <= w_dp_act ^ ACTIVE_LOW;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule

// File: tb/tb_seg_display_mux.sv
// Bench for seg_display_mux (REFRESH_DIV=8, BLANK_CYCLES=2, common anode):
// time-based reference model checked every cycle, frame tables and corner sequences.
module tb_seg_display_mux;

  localparam int unsigned RDIV  = 8;
  localparam int unsigned BLANK = 2;
  localparam int unsigned FRAME = 4 * RDIV;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] digit_min, digit_st, digit_su, digit_tenths;
  logic       blank_lead;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_checks = 0;
  int n_errors = 0;

  seg_display_mux #(
    .REFRESH_DIV (RDIV),
    .BLANK_CYCLES(BLANK),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .digit_min   (digit_min),
    .digit_st    (digit_st),
    .digit_su    (digit_su),
    .digit_tenths(digit_tenths),
    .blank_lead  (blank_lead),
    .an          (an),
    .seg         (seg),
    .dp          (dp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: frame position derived from clock count since reset.
  logic [6:0] dec_tab [16];
  logic [3:0] m_snap [4];
  int         m_edges = 0;
  logic [3:0] exp_an  = 4'hF;
  logic [6:0] exp_seg = 7'h7F;
  logic       exp_dp  = 1'b1;

  initial begin
    dec_tab[0] = 7'h3F; dec_tab[1] = 7'h06; dec_tab[2] = 7'h5B; dec_tab[3] = 7'h4F;
    dec_tab[4] = 7'h66; dec_tab[5] = 7'h6D; dec_tab[6] = 7'h7D; dec_tab[7] = 7'h07;
    dec_tab[8] = 7'h7F; dec_tab[9] = 7'h6F;
    for (int k = 10; k < 16; k++) dec_tab[k] = 7'h00;
    for (int k = 0; k < 4; k++) m_snap[k] = 4'd0;
  end

  always @(posedge clk or posedge rst) begin
    int p, i, s;
    logic [3:0] a_an;
    logic [6:0] a_seg;
    logic       a_dp;
    if (rst) begin
      m_edges = 0;
      for (int k = 0; k < 4; k++) m_snap[k] = 4'd0;
      exp_an  = 4'hF;
      exp_seg = 7'h7F;
      exp_dp  = 1'b1;
    end else begin
      p = m_edges % FRAME;
      i = p / RDIV;
      s = p % RDIV;
      a_an = 4'h0; a_seg = 7'h00; a_dp = 1'b0;
      if (s >= BLANK && !(i == 3 && blank_lead && m_snap[3] == 4'd0)) begin
        a_an  = 4'(1 << i);
        a_seg = dec_tab[m_snap[i]];
        a_dp  = (i == 1) || (i == 3);
      end
      exp_an  = ~a_an;
      exp_seg = ~a_seg;
      exp_dp  = ~a_dp;
      if (p == FRAME - 1) begin
        m_snap[0] = digit_tenths;
        m_snap[1] = digit_su;
        m_snap[2] = digit_st;
        m_snap[3] = digit_min;
      end
      m_edges++;
    end
  end

  always @(negedge clk) begin
    chk("model_an",  16'(an),  16'(exp_an));
    chk("model_seg", 16'(seg), 16'(exp_seg));
    chk("model_dp",  16'(dp),  16'(exp_dp));
  end

  typedef struct {
    logic [3:0]      mn, st, su, tn;
    logic            bl;
    logic [3:0][6:0] eseg;
    logic            eblank3;
  } vec_t;

  vec_t vecs [5];

  task automatic set_digits(input logic [3:0] mn, input logic [3:0] st,
                            input logic [3:0] su, input logic [3:0] tn, input logic bl);
    digit_min = mn; digit_st = st; digit_su = su; digit_tenths = tn; blank_lead = bl;
  endtask

  // Park on the negedge whose outputs show idx 0, slot 0 of a frame.
  task automatic sync_frame();
    int guard = 0;
    @(negedge clk);
    while ((m_edges % FRAME) != 1 && guard < 3 * FRAME) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 3 * FRAME) begin
      n_checks++;
      n_errors++;
      $display("FAIL sync_frame: frame start not reached within %0d cycles", guard);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_frame(input vec_t v, input int vi);
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    for (int i = 0; i < 4; i++) begin
      for (int s = 0; s < int'(RDIV); s++) begin
        if (s < int'(BLANK) || (i == 3 && v.eblank3)) begin
          e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
        end else begin
          e_an = ~(4'(1 << i)); e_seg = v.eseg[i]; e_dp = (i % 2 == 1) ? 1'b0 : 1'b1;
        end
        chk($sformatf("vec%0d_i%0d_s%0d_an", vi, i, s), 16'(an), 16'(e_an));
        chk($sformatf("vec%0d_i%0d_s%0d_seg", vi, i, s), 16'(seg), 16'(e_seg));
        chk($sformatf("vec%0d_i%0d_s%0d_dp", vi, i, s), 16'(dp), 16'(e_dp));
        @(negedge clk);
      end
    end
  endtask

  initial begin
    vecs[0] = '{4'h1, 4'h2, 4'h3, 4'h4, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, 1'b0};
    vecs[1] = '{4'h0, 4'h5, 4'h9, 4'h8, 1'b1, {7'h40, 7'h12, 7'h10, 7'h00}, 1'b1};
    vecs[2] = '{4'h0, 4'h0, 4'h0, 4'h0, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}, 1'b0};
    vecs[3] = '{4'h9, 4'h6, 4'h7, 4'hC, 1'b1, {7'h10, 7'h02, 7'h78, 7'h7F}, 1'b0};
    vecs[4] = '{4'hF, 4'h1, 4'h2, 4'h5, 1'b1, {7'h7F, 7'h79, 7'h24, 7'h12}, 1'b0};

    // Reset held with nonzero digits: outputs stay inactive.
    rst = 1'b1;
    set_digits(4'h9, 4'h5, 4'h9, 4'h9, 1'b0);
    step(4);
    chk("reset_an", 16'(an), 16'hF);
    chk("reset_seg", 16'(seg), 16'h7F);
    chk("reset_dp", 16'(dp), 16'h1);
    rst = 1'b0;

    // First frame shows the zero snapshot after two blank clocks.
    step(1);
    chk("rel_blank0_an", 16'(an), 16'hF);
    step(1);
    chk("rel_blank1_an", 16'(an), 16'hF);
    step(1);
    chk("rel_lit_an", 16'(an), 16'hE);
    chk("rel_lit_seg", 16'(seg), 16'h40);

    // Frame tables.
    for (int v = 0; v < 5; v++) begin
      set_digits(vecs[v].mn, vecs[v].st, vecs[v].su, vecs[v].tn, vecs[v].bl);
      sync_frame();
      sync_frame();
      check_frame(vecs[v], v);
    end

    // Leading-zero blanking follows live blank_lead within the frame.
    set_digits(4'h0, 4'h2, 4'h3, 4'h4, 1'b1);
    sync_frame();
    sync_frame();
    step(3 * RDIV + 4);
    chk("lzb_on_an", 16'(an), 16'hF);
    chk("lzb_on_dp", 16'(dp), 16'h1);
    blank_lead = 1'b0;
    step(1);
    chk("lzb_off_an", 16'(an), 16'h7);
    chk("lzb_off_seg", 16'(seg), 16'h40);
    chk("lzb_off_dp", 16'(dp), 16'h0);

    // Snapshot holds a mid-frame digit change until the next frame.
    set_digits(4'h1, 4'h2, 4'h3, 4'h4, 1'b0);
    sync_frame();
    sync_frame();
    step(4);
    digit_su = 4'h7;
    step(8);
    chk("tear_same_an", 16'(an), 16'hD);
    chk("tear_same_seg", 16'(seg), 16'h30);
    sync_frame();
    step(12);
    chk("tear_next_an", 16'(an), 16'hD);
    chk("tear_next_seg", 16'(seg), 16'h78);

    // Async reset mid idx=2 slot, between clock edges.
    sync_frame();
    step(2 * RDIV + 4);
    chk("arst_pre_an", 16'(an), 16'hB);
    #1 rst = 1'b1;
    #1;
    chk("arst_an", 16'(an), 16'hF);
    chk("arst_seg", 16'(seg), 16'h7F);
    chk("arst_dp", 16'(dp), 16'h1);
    step(2);
    rst = 1'b0;
    step(1);
    chk("arst_rel0_an", 16'(an), 16'hF);
    step(1);
    chk("arst_rel1_an", 16'(an), 16'hF);
    step(1);
    chk("arst_rel2_an", 16'(an), 16'hE);
    chk("arst_rel2_seg", 16'(seg), 16'h40);

    // Randomized digits and blank_lead against the model.
    for (int c = 0; c < 1600; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 9) == 0) begin
        digit_min    = 4'($urandom_range(0, 15));
        digit_st     = 4'($urandom_range(0, 15));
        digit_su     = 4'($urandom_range(0, 15));
        digit_tenths = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 2) == 0) digit_min = 4'd0;
      end
      if ($urandom_range(0, 19) == 0) blank_lead = ~blank_lead;
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
